// File: rtl/uart_rx_if.sv
// Serial-line side of the UART receiver: line input plus received-word outputs.
// slave = receiver, master = whatever drives the line and consumes words.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  // o_data_valid is a one-cycle pulse with no backpressure.
  // o_data, o_parity_err and o_frame_err are only meaningful in that cycle.
  // o_data additionally holds its value until the next completed frame.
  logic                  i_uart_rx;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_data_valid;
  logic                  o_parity_err;
  logic                  o_frame_err;

  modport slave (
    input  i_uart_rx,
    output o_data,
    output o_data_valid,
    output o_parity_err,
    output o_frame_err
  );

  modport master (
    output i_uart_rx,
    input  o_data,
    input  o_data_valid,
    input  o_parity_err,
    input  o_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, optional parity, break-aware stop handling.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit instead of a single sample.
module uart_rx #(
  parameter int CLK_FRE     = 50,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_ON   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       i_clk_sys,
  input  logic       i_rst_n,
  uart_rx_if.slave   bus,
  output logic [2:0] o_dbg_state
);

  localparam int          CYCLE    = CLK_FRE * 1_000_000 / BAUD_RATE;
  localparam logic [15:0] CNT_LAST = 16'(CYCLE - 1);
  localparam logic [15:0] CNT_MID  = 16'(CYCLE / 2);
  localparam logic [3:0]  BITS     = 4'(DATA_WIDTH);
  localparam logic        PTYPE    = (PARITY_TYPE != 0);
  localparam logic        PAR_EN   = (PARITY_ON != 0);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t                state;
  logic                  rx_meta;
  logic                  rx_s;
  logic                  rx_prev;
  logic [15:0]           baud_cnt;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_err_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  mid;
  logic                  wrap;
  logic                  bit_s;

  assign mid  = (baud_cnt == CNT_MID);
  assign wrap = (baud_cnt == CNT_LAST);

  // Line idles high, so the synchroniser and edge history reset to 1.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= bus.i_uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [15:0] CNT_M2 = 16'(CYCLE / 2 - 2);
  localparam logic [15:0] CNT_M1 = 16'(CYCLE / 2 - 1);
  logic [1:0] maj_q;

  // The two samples ahead of mid-bit vote together with the live one at mid-bit.
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      maj_q <= 2'b11;
    end else begin
      if (baud_cnt == CNT_M2) maj_q[0] <= rx_s;
      if (baud_cnt == CNT_M1) maj_q[1] <= rx_s;
    end
  end

  assign bit_s = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s) | (maj_q[1] & rx_s);
`else
  assign bit_s = rx_s;
`endif

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      baud_cnt  <= 16'd0;
      bit_cnt   <= 4'd0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;

      if (state == IDLE || state == WAIT_HIGH || wrap) baud_cnt <= 16'd0;
      else                                             baud_cnt <= baud_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state   <= START;
            bit_cnt <= 4'd0;
          end
        end
        START: begin
          // A start bit that is high again at mid-bit was noise.
          if (mid && bit_s) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (mid) begin
            shift_q <= {bit_s, shift_q[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
          if (wrap && bit_cnt == BITS) begin
            bit_cnt <= 4'd0;
            state   <= PAR_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (mid)  par_err_q <= ((^shift_q) ^ bit_s) != PTYPE;
          if (wrap) state     <= STOP;
        end
        STOP: begin
          // Deliver at mid stop bit so a back-to-back start bit is never missed.
          if (mid) begin
            data_q   <= shift_q;
            valid_q  <= 1'b1;
            perr_q   <= PAR_EN & par_err_q;
            ferr_q   <= ~bit_s;
            state    <= bit_s ? IDLE : WAIT_HIGH;
            baud_cnt <= 16'd0;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= 16'd0;
        end
      endcase
    end
  end

  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_parity_err = perr_q;
  assign bus.o_frame_err  = ferr_q;
  assign o_dbg_state      = state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one receiver without parity, one with even parity, random and directed frames.
module tb_uart_rx;

  localparam int CLK_FRE = 50;
  localparam int BAUD    = 500_000;
  localparam int CYC     = 100;
  localparam int HALF    = 50;
  localparam int DW      = 8;
  localparam int PTYPE   = 0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg0;
  logic [2:0] dbg1;

  always #5 clk = ~clk;

  uart_rx_if #(.DATA_WIDTH(DW)) bus0 ();
  uart_rx_if #(.DATA_WIDTH(DW)) bus1 ();

  uart_rx #(.CLK_FRE(CLK_FRE), .DATA_WIDTH(DW), .PARITY_ON(0), .PARITY_TYPE(PTYPE), .BAUD_RATE(BAUD))
    dut0 (.i_clk_sys(clk), .i_rst_n(rst_n), .bus(bus0.slave), .o_dbg_state(dbg0));

  uart_rx #(.CLK_FRE(CLK_FRE), .DATA_WIDTH(DW), .PARITY_ON(1), .PARITY_TYPE(PTYPE), .BAUD_RATE(BAUD))
    dut1 (.i_clk_sys(clk), .i_rst_n(rst_n), .bus(bus1.slave), .o_dbg_state(dbg1));

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected word per frame: {frame_err, parity_err, data}
  logic [DW+1:0] exp_q0[$];
  logic [DW+1:0] exp_q1[$];
  logic [DW-1:0] last0 = '0;
  logic [DW-1:0] last1 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  always @(negedge clk) begin : mon0
    logic [DW+1:0] e;
    if (!rst_n) begin
      check("rst_out0", {bus0.o_data_valid, bus0.o_frame_err, bus0.o_parity_err, bus0.o_data}, 0);
      last0 = '0;
    end else if (bus0.o_data_valid) begin
      if (exp_q0.size() == 0) check("unexp_valid0", 1, 0);
      else begin
        e = exp_q0.pop_front();
        check("frame0", {bus0.o_frame_err, bus0.o_parity_err, bus0.o_data}, e);
        last0 = e[DW-1:0];
      end
    end else begin
      check("hold0", {bus0.o_frame_err, bus0.o_parity_err, bus0.o_data}, {2'b00, last0});
    end
  end

  always @(negedge clk) begin : mon1
    logic [DW+1:0] e;
    if (!rst_n) begin
      check("rst_out1", {bus1.o_data_valid, bus1.o_frame_err, bus1.o_parity_err, bus1.o_data}, 0);
      last1 = '0;
    end else if (bus1.o_data_valid) begin
      if (exp_q1.size() == 0) check("unexp_valid1", 1, 0);
      else begin
        e = exp_q1.pop_front();
        check("frame1", {bus1.o_frame_err, bus1.o_parity_err, bus1.o_data}, e);
        last1 = e[DW-1:0];
      end
    end else begin
      check("hold1", {bus1.o_frame_err, bus1.o_parity_err, bus1.o_data}, {2'b00, last1});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int which, input logic v);
    if (which == 0) bus0.i_uart_rx = v;
    else            bus1.i_uart_rx = v;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit period; a glitch is a single low clock landing on the mid-bit sample.
  task automatic bit_period(input int which, input logic v, input logic glitch);
    drive(which, v);
    if (glitch) begin
      wait_clks(HALF + 1);
      drive(which, 1'b0);
      wait_clks(1);
      drive(which, 1'b1);
      wait_clks(CYC - HALF - 2);
    end else begin
      wait_clks(CYC);
    end
  endtask

  task automatic send_frame(input int which, input logic [DW-1:0] data, input logic bad_par,
                            input logic stop_hi, input int low_periods, input int glitch_bit);
    logic [DW-1:0] rx_data;
    logic          pbit;
    logic          pe;
    rx_data = data;
`ifndef UART_RX_MAJORITY_EN
    if (glitch_bit >= 0) rx_data[glitch_bit] = 1'b0;
`endif
    pbit = (($countones(data) % 2) != PTYPE) ^ bad_par;
    pe   = (which == 1) && ((($countones(rx_data) + int'(pbit)) % 2) != PTYPE);
    if (which == 0) exp_q0.push_back({~stop_hi, pe, rx_data});
    else            exp_q1.push_back({~stop_hi, pe, rx_data});
    bit_period(which, 1'b0, 1'b0);
    for (int i = 0; i < DW; i++) bit_period(which, data[i], glitch_bit == i);
    if (which == 1) bit_period(which, pbit, 1'b0);
    if (stop_hi) begin
      bit_period(which, 1'b1, 1'b0);
    end else begin
      for (int p = 0; p < low_periods; p++) bit_period(which, 1'b0, 1'b0);
      drive(which, 1'b1);
      wait_clks(CYC);
    end
  endtask

  task automatic random_frames(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      send_frame(which, DW'($urandom), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) != 0, $urandom_range(1, 3), -1);
      wait_clks($urandom_range(0, 2 * CYC));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int            len;
    int            gb;
    logic [DW-1:0] d;
    bus0.i_uart_rx = 1'b1;
    bus1.i_uart_rx = 1'b1;
    rst_n = 1'b0;
    wait_clks(3);
    check("rst_state0", {dbg0, bus0.o_data_valid, bus0.o_frame_err, bus0.o_parity_err, bus0.o_data}, 0);
    check("rst_state1", {dbg1, bus1.o_data_valid, bus1.o_frame_err, bus1.o_parity_err, bus1.o_data}, 0);
    rst_n = 1'b1;
    wait_clks(CYC);

    // Basic frame, no parity
    send_frame(0, 8'hA5, 1'b0, 1'b1, 0, -1);
    wait_clks(CYC);

    // False start shorter than half a bit, then a real frame
    len = $urandom_range(5, HALF - 5);
    drive(0, 1'b0);
    wait_clks(len);
    drive(0, 1'b1);
    wait_clks(CYC);
    check("false_start_idle", dbg0, 0);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 0, -1);
    wait_clks(CYC);

    // Break: stop bit low, line held low for 3 bit periods, then a normal frame
    send_frame(0, 8'h0F, 1'b0, 1'b0, 3, -1);
    send_frame(0, 8'h96, 1'b0, 1'b1, 0, -1);
    wait_clks(CYC);

    // Reset pulsed during data bit 4: partial frame is dropped
    d = 8'h3C;
    bit_period(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_period(0, d[i], 1'b0);
    drive(0, d[4]);
    wait_clks(HALF / 2);
    rst_n = 1'b0;
    drive(0, 1'b1);
    #1;
    check("rst_async0", {bus0.o_data_valid, bus0.o_frame_err, bus0.o_parity_err, bus0.o_data}, 0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2 * CYC);
    send_frame(0, 8'hC3, 1'b0, 1'b1, 0, -1);
    wait_clks(CYC);

    // Single-clock glitch on the mid-bit sample of a 1 bit
    gb = $urandom_range(0, DW - 1);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 0, gb);
    wait_clks(CYC);

    random_frames(0, 10);

    // Even parity receiver: correct then corrupted parity bit
    send_frame(1, 8'h03, 1'b0, 1'b1, 0, -1);
    send_frame(1, 8'h03, 1'b1, 1'b1, 0, -1);
    wait_clks(CYC);
    random_frames(1, 10);

    wait_clks(2 * CYC);
    check("pending0", exp_q0.size(), 0);
    check("pending1", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
